// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with fetch/commit FSM, single-level
// exception entry/return, double-fault halt and retired-instruction counter.
`default_nettype none

module pc_seq_unit #(
  parameter int              PC_W  = 8,
  parameter int              JW    = 6,
  parameter logic [PC_W-1:0] VEC   = PC_W'(8'h80),
  parameter int              CNT_W = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             SYS_load,
  input  logic [PC_W-1:0]  SYS_pc_val,
  input  logic             run,
  output logic             imem_req,
  input  logic             instr_done,
  input  logic             br_take,
  input  logic [PC_W-1:0]  br_off,
  input  logic             jmp,
  input  logic [JW-1:0]    jmp_tgt,
  input  logic             eret,
  input  logic             exc_ovf,
  input  logic             exc_undef,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  epc,
  output logic [3:0]       cause,
  output logic             exc_active,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_TRAP   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] CAUSE_OVF    = 4'd1;
  localparam logic [3:0] CAUSE_UNDEF  = 4'd2;
  localparam logic [3:0] CAUSE_MISAL  = 4'd3;
  localparam logic [3:0] CAUSE_DOUBLE = 4'hF;

  state_t          st;
  logic [3:0]      trap_code;
  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] next_pc;
  logic            eret_ok;

  assign state    = st;
  assign imem_req = (st == S_FETCH);
  assign pc4      = pc + PC_W'(4);
  // eret outside a handler is a plain sequential commit
  assign eret_ok  = eret && exc_active;

  always_comb begin
    next_pc = pc4;
    if (eret_ok)
      next_pc = epc + PC_W'(4);
    else if (eret)
      next_pc = pc4;
    else if (jmp)
      next_pc = {pc4[PC_W-1:JW], jmp_tgt};
    else if (br_take)
      next_pc = pc4 + (br_off << 2);
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      st         <= S_IDLE;
      pc         <= '0;
      epc        <= '0;
      cause      <= '0;
      exc_active <= 1'b0;
      halted     <= 1'b0;
      retired    <= '0;
      trap_code  <= '0;
    end else if (SYS_load) begin
      pc         <= SYS_pc_val;
      st         <= S_IDLE;
      halted     <= 1'b0;
      exc_active <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run) st <= S_FETCH;
        end
        S_FETCH: begin
          if (pc[1:0] != 2'b00) begin
            trap_code <= CAUSE_MISAL;
            st        <= S_TRAP;
          end else begin
            st <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (instr_done) begin
            if (exc_undef) begin
              trap_code <= CAUSE_UNDEF;
              st        <= S_TRAP;
            end else if (exc_ovf) begin
              trap_code <= CAUSE_OVF;
              st        <= S_TRAP;
            end else begin
              st <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          pc      <= next_pc;
          retired <= retired + CNT_W'(1);
          if (eret_ok) exc_active <= 1'b0;
          st <= run ? S_FETCH : S_IDLE;
        end
        S_TRAP: begin
          // a fault while already in the handler is unrecoverable
          if (!exc_active) begin
            epc        <= pc;
            cause      <= trap_code;
            pc         <= VEC;
            exc_active <= 1'b1;
            st         <= S_FETCH;
          end else begin
            cause  <= CAUSE_DOUBLE;
            halted <= 1'b1;
            st     <= S_HALT;
          end
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: begin
          st <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_seq_unit.sv
// Randomized bench for pc_seq_unit against an instruction-level model.
`default_nettype none

module tb_pc_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  pc_val = '0;
  logic        run = 1'b0;
  logic        imem_req;
  logic        instr_done = 1'b0;
  logic        br_take = 1'b0;
  logic [7:0]  br_off = '0;
  logic        jmp = 1'b0;
  logic [5:0]  jmp_tgt = '0;
  logic        eret = 1'b0;
  logic        exc_ovf = 1'b0;
  logic        exc_undef = 1'b0;
  logic [7:0]  pc, epc;
  logic [3:0]  cause;
  logic        exc_active, halted;
  logic [15:0] retired;
  logic [2:0]  state;

  // architectural model state
  logic [7:0]  m_pc, m_epc;
  logic [3:0]  m_cause;
  logic        m_exc, m_halt;
  logic [15:0] m_ret;

  int n_chk  = 0;
  int n_pass = 0;

  pc_seq_unit dut (
    .SYS_clk    (clk),
    .SYS_reset  (rst),
    .SYS_load   (load),
    .SYS_pc_val (pc_val),
    .run        (run),
    .imem_req   (imem_req),
    .instr_done (instr_done),
    .br_take    (br_take),
    .br_off     (br_off),
    .jmp        (jmp),
    .jmp_tgt    (jmp_tgt),
    .eret       (eret),
    .exc_ovf    (exc_ovf),
    .exc_undef  (exc_undef),
    .pc         (pc),
    .epc        (epc),
    .cause      (cause),
    .exc_active (exc_active),
    .halted     (halted),
    .retired    (retired),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    m_pc = '0; m_epc = '0; m_cause = '0; m_exc = 1'b0; m_halt = 1'b0; m_ret = '0;
  endtask

  task automatic m_trap(input logic [3:0] code);
    if (!m_exc) begin
      m_epc = m_pc; m_cause = code; m_pc = 8'h80; m_exc = 1'b1;
    end else begin
      m_cause = 4'hF; m_halt = 1'b1;
    end
  endtask

  task automatic m_commit(input bit e, input bit j, input logic [5:0] t,
                          input bit b, input logic [7:0] o);
    logic [7:0] seq;
    seq = m_pc + 8'd4;
    if (e && m_exc) begin
      m_pc = m_epc + 8'd4; m_exc = 1'b0;
    end else if (e)  m_pc = seq;
    else if (j)      m_pc = {seq[7:6], t};
    else if (b)      m_pc = 8'(seq + o * 8'd4);
    else             m_pc = seq;
    m_ret = m_ret + 16'd1;
  endtask

  task automatic check_arch(input string tag, input logic [2:0] exp_state);
    chk({tag, ":pc"},      pc,         m_pc);
    chk({tag, ":epc"},     epc,        m_epc);
    chk({tag, ":cause"},   cause,      m_cause);
    chk({tag, ":exc"},     exc_active, m_exc);
    chk({tag, ":halted"},  halted,     m_halt);
    chk({tag, ":retired"}, retired,    m_ret);
    chk({tag, ":state"},   state,      exp_state);
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 40 && !(imem_req || state == 3'd5); i++) tick();
    if (state != 3'd5) chk("fetch_wait", imem_req, 1);
  endtask

  task automatic sys_load(input logic [7:0] val);
    load = 1'b1; pc_val = val;
    tick();
    load = 1'b0;
    m_pc = val; m_exc = 1'b0; m_halt = 1'b0;
    check_arch("load", 3'd0);
  endtask

  // One instruction from fetch to resolution; called at a sample point.
  task automatic do_instr(input bit ovf, input bit undef, input int dly,
                          input bit b, input logic [7:0] o,
                          input bit j, input logic [5:0] t,
                          input bit e, input bit run_after);
    wait_fetch();
    if (state == 3'd5) return;
    chk("fetch_pc", pc, m_pc);
    if (m_pc[1:0] != 2'b00) begin
      tick();
      chk("misal_state", state, 3'd4);
      tick();
      m_trap(4'd3);
      check_arch("misal", m_halt ? 3'd5 : 3'd1);
      return;
    end
    exc_ovf = ovf; exc_undef = undef; br_take = b; br_off = o;
    jmp = j; jmp_tgt = t; eret = e; instr_done = 1'b0;
    tick();
    chk("wait_state", state, 3'd2);
    chk("req_pulse", imem_req, 0);
    for (int i = 0; i < dly; i++) tick();
    instr_done = 1'b1; run = run_after;
    tick();
    instr_done = 1'b0; exc_ovf = 1'b0; exc_undef = 1'b0;
    tick();
    br_take = 1'b0; jmp = 1'b0; eret = 1'b0;
    if (undef || ovf) begin
      m_trap(undef ? 4'd2 : 4'd1);
      check_arch("trap", m_halt ? 3'd5 : 3'd1);
    end else begin
      m_commit(e, j, t, b, o);
      check_arch("commit", run_after ? 3'd1 : 3'd0);
    end
    run = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":pc"}, pc, 0);       chk({tag, ":epc"}, epc, 0);
    chk({tag, ":cause"}, cause, 0); chk({tag, ":exc"}, exc_active, 0);
    chk({tag, ":halted"}, halted, 0); chk({tag, ":retired"}, retired, 0);
    chk({tag, ":state"}, state, 0); chk({tag, ":req"}, imem_req, 0);
  endtask

  initial begin
    m_reset();
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_hold", state, 3'd0);

    // sequential fetch, count, wrap
    run = 1'b1;
    tick();
    chk("first_fetch", state, 3'd1);
    for (int k = 0; k < 3; k++) do_instr(0, 0, k, 0, 8'h0, 0, 6'h0, 0, 1);
    chk("seq_pc", pc, 8'h0C);
    chk("seq_retired", retired, 16'd3);
    sys_load(8'hFC);
    do_instr(0, 0, 0, 0, 8'h0, 0, 6'h0, 0, 1);
    chk("wrap_pc", pc, 8'h00);

    // branch and jump priority
    sys_load(8'h10);
    do_instr(0, 0, 1, 1, 8'hFE, 0, 6'h0, 0, 1);
    chk("br_back", pc, 8'h0C);
    sys_load(8'h10);
    do_instr(0, 0, 0, 1, 8'h05, 1, 6'h3C, 0, 0);
    chk("jmp_over_br", pc, 8'h3C);

    // overflow trap and return
    sys_load(8'h20);
    do_instr(1, 0, 2, 0, 8'h0, 0, 6'h0, 0, 1);
    chk("ovf_epc", epc, 8'h20);
    chk("ovf_cause", cause, 4'd1);
    chk("ovf_pc", pc, 8'h80);
    do_instr(0, 0, 0, 0, 8'h0, 0, 6'h0, 0, 1);
    do_instr(0, 0, 0, 0, 8'h0, 1, 6'h11, 1, 1);
    chk("eret_pc", pc, 8'h24);
    chk("eret_exc", exc_active, 0);

    // misaligned fetch then double fault
    sys_load(8'h06);
    do_instr(0, 0, 0, 0, 8'h0, 0, 6'h0, 0, 1);
    chk("misal_cause", cause, 4'd3);
    chk("misal_pc", pc, 8'h80);
    do_instr(0, 1, 0, 0, 8'h0, 0, 6'h0, 0, 1);
    chk("dbl_cause", cause, 4'hF);
    chk("dbl_epc", epc, 8'h06);
    tick(); tick();
    chk("halt_stays", state, 3'd5);
    chk("halt_flag", halted, 1);

    // load during WAIT overrides completion
    sys_load(8'h40);
    wait_fetch();
    instr_done = 1'b0;
    tick();
    chk("mid_wait", state, 3'd2);
    load = 1'b1; pc_val = 8'h18; instr_done = 1'b1;
    tick();
    load = 1'b0; instr_done = 1'b0;
    m_pc = 8'h18; m_exc = 1'b0; m_halt = 1'b0;
    check_arch("load_wait", 3'd0);

    // randomized instruction stream
    for (int n = 0; n < 250; n++) begin
      if (m_halt) begin
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
        sys_load(v);
      end else begin
        bit u, ov;
        u  = ($urandom_range(0, 11) == 0);
        ov = ($urandom_range(0, 7) == 0);
        do_instr(ov, u, $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), 8'($urandom),
                 ($urandom_range(0, 5) == 0), 6'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) != 0));
      end
    end

    // asynchronous reset in the middle of TRAP
    sys_load(8'h30);
    wait_fetch();
    exc_ovf = 1'b1; instr_done = 1'b1;
    tick();
    tick();
    chk("pre_reset_trap", state, 3'd4);
    rst = 1'b1;
    #1 chk_zero("trap_reset");
    exc_ovf = 1'b0; instr_done = 1'b0;
    m_reset();
    tick();
    rst = 1'b0;
    chk("held_idle", state, 3'd0);
    tick();
    chk("release_fetch", state, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_seq_unit.md
PC_SEQ_UNIT -- requirements
Module: pc_seq_unit

Interface
REQ-001 Parameter PC_W, default 8, PC/EPC/target width in bits.
REQ-002 Parameter JW, default 6, jump-target field width; JW < PC_W.
REQ-003 Parameter VEC, default 8'h80 (PC_W bits), exception handler address.
REQ-004 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-005 SYS_clk  in  1  sole clock, rising edge.
REQ-006 SYS_reset  in  1  asynchronous, active-high reset.
REQ-007 SYS_load  in  1  synchronous PC load strobe.
REQ-008 SYS_pc_val  in  PC_W  PC value for SYS_load.
REQ-009 run  in  1  enables sequencing out of IDLE.
REQ-010 imem_req  out  1  fetch request, PC valid.
REQ-011 instr_done  in  1  datapath finished current instruction.
REQ-012 br_take  in  1  conditional branch taken.
REQ-013 br_off  in  PC_W  signed word offset.
REQ-014 jmp  in  1  jump.
REQ-015 jmp_tgt  in  JW  jump-target field.
REQ-016 eret  in  1  return from exception.
REQ-017 exc_ovf, exc_undef  in  1 each  overflow / undefined-opcode flags.
REQ-018 pc, epc  out  PC_W each  current PC, exception PC.
REQ-019 cause  out  4  exception cause code.
REQ-020 exc_active, halted  out  1 each  in-handler flag, double-fault halt flag.
REQ-021 retired  out  CNT_W  committed-instruction count.
REQ-022 state  out  3  FSM state encoding.

Function
REQ-023 Outputs SHALL be registered; imem_req SHALL be decoded from state only.
REQ-024 States SHALL be IDLE=0, FETCH=1, WAIT=2, COMMIT=3, TRAP=4, HALT=5.
REQ-025 IDLE->FETCH when run=1; otherwise hold.
REQ-026 FETCH: imem_req=1 for exactly one cycle; go to TRAP with cause=3 if pc[1:0]!=0, else go to WAIT.
REQ-027 WAIT: hold until instr_done=1; then go to TRAP if exc_undef or exc_ovf is sampled high that cycle, else go to COMMIT.
REQ-028 Cause priority SHALL be misaligned fetch=3 > undefined=2 > overflow=1.
REQ-029 COMMIT: update pc, increment retired (modulo 2^CNT_W), then go to FETCH if run=1, else go to IDLE.
REQ-030 Next-PC priority SHALL be eret (pc<=epc+4, exc_active<=0) > jmp (pc<={pc4[PC_W-1:JW], jmp_tgt}) > br_take (pc<=pc4+(br_off<<2)) > pc4, where pc4=pc+4.
REQ-031 All PC arithmetic SHALL be modulo 2^PC_W, with no wrap flag.
REQ-032 TRAP with exc_active=0: epc<=pc, cause<=code, pc<=VEC, exc_active<=1, retired unchanged, then go to FETCH.
REQ-033 TRAP with exc_active=1 (double fault): epc held, cause<=4'hF, halted<=1, then go to HALT.
REQ-034 HALT SHALL be left only via SYS_reset or SYS_load.
REQ-035 SYS_load in any state: pc<=SYS_pc_val, state<=IDLE, halted<=0, exc_active<=0; epc, cause and retired are held; SYS_load overrides all same-cycle transitions.
REQ-036 eret with exc_active=0 SHALL behave as a plain pc4 commit.

Reset
REQ-037 SYS_reset=1 SHALL immediately force pc=0, epc=0, cause=0, retired=0, exc_active=0, halted=0, state=IDLE, imem_req=0, in any state, including mid-TRAP.
REQ-038 First state change after reset release SHALL occur on the first rising edge with SYS_reset=0.

Verification
REQ-039 Reset, run=1, instr_done=1 each WAIT -> pc sequence 0x00, 0x04, 0x08; retired=3; from pc=0xFC next pc=0x00.
REQ-040 pc=0x10, br_take=1, br_off=0xFE -> pc=0x0C; pc=0x10, jmp=1 and br_take=1, jmp_tgt=0x3C -> pc=0x3C.
REQ-041 exc_ovf=1 with instr_done at pc=0x20 -> epc=0x20, cause=1, pc=0x80, exc_active=1, retired unchanged; eret at pc=0x84 -> pc=0x24, exc_active=0.
REQ-042 SYS_load 0x06 then run -> TRAP with cause=3, pc=0x80; exc_undef inside handler -> cause=0xF, halted=1, state=HALT, epc=0x06 held.
REQ-043 SYS_load=1, SYS_pc_val=0x18 during WAIT at pc=0x40 -> state IDLE, pc=0x18, retired unchanged; SYS_reset asserted mid-TRAP -> all outputs zero before the next clock edge.
